// File: rtl/vector_accumulator.sv
// Element-wise accumulator for a run of feature vectors with valid/ready handshakes on both sides.
// Define VECTOR_ACC_SAT_EN to make each lane saturate instead of wrapping.
module vector_accumulator #(
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int MAX_VECTORS    = 16,
    localparam int CNT_W         = $clog2(MAX_VECTORS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_vectors,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DOT_PROD_WIDTH-1:0] in_vector  [0:WEIGHT_COLS-1],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DOT_PROD_WIDTH-1:0] out_vector [0:WEIGHT_COLS-1],
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          length;
    logic [CNT_W-1:0]          num_clamped;
    logic [DOT_PROD_WIDTH-1:0] acc      [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] acc_next [0:WEIGHT_COLS-1];
    logic                      accept;
    logic                      last;

`ifdef VECTOR_ACC_SAT_EN
    logic [DOT_PROD_WIDTH:0]   lane_sum [0:WEIGHT_COLS-1];
`endif

    assign num_clamped = (num_vectors > CNT_W'(MAX_VECTORS)) ? CNT_W'(MAX_VECTORS) : num_vectors;
    assign accept      = (state == ACCUM) && in_valid;
    assign last        = accept && (count == (length - CNT_W'(1)));
    assign in_ready    = (state == ACCUM);
    assign busy        = (state != IDLE);

    // A lane pinned at all-ones stays there, since adding an unsigned value can only carry out again.
    always_comb begin
        for (int i = 0; i < WEIGHT_COLS; i++) begin
`ifdef VECTOR_ACC_SAT_EN
            lane_sum[i] = {1'b0, acc[i]} + {1'b0, in_vector[i]};
            acc_next[i] = lane_sum[i][DOT_PROD_WIDTH] ? {DOT_PROD_WIDTH{1'b1}}
                                                      : lane_sum[i][DOT_PROD_WIDTH-1:0];
`else
            acc_next[i] = acc[i] + in_vector[i];
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_vectors == '0) ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                if (last) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // out_vector is captured from the final adder result so it is valid one cycle after the last accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            length    <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < WEIGHT_COLS; i++) begin
                acc[i]        <= '0;
                out_vector[i] <= '0;
            end
        end else begin
            out_valid <= (state_next == OUTPUT);
            if ((state == IDLE) && start) begin
                count  <= '0;
                length <= num_clamped;
                for (int i = 0; i < WEIGHT_COLS; i++) begin
                    acc[i] <= '0;
                    if (num_vectors == '0) begin
                        out_vector[i] <= '0;
                    end
                end
            end else if (accept) begin
                count <= count + CNT_W'(1);
                for (int i = 0; i < WEIGHT_COLS; i++) begin
                    acc[i] <= acc_next[i];
                    if (last) begin
                        out_vector[i] <= acc_next[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_accumulator.sv
// Scoreboard bench for vector_accumulator: a lane model pushes expected sums as vectors are driven,
// and each scenario task pops and compares when the DUT presents its result.
module tb_vector_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  num_vectors = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vector [0:2];
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_vector [0:2];
    logic        busy;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [47:0] exp_q [$];
    logic [15:0] m_acc [0:2];
    int          m_len;
    int          m_cnt;

    vector_accumulator dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_vectors (num_vectors),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vector   (in_vector),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vector  (out_vector),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] lane_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef VECTOR_ACC_SAT_EN
        return s[16] ? 16'hFFFF : s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    function automatic logic [47:0] out_packed();
        return {out_vector[0], out_vector[1], out_vector[2]};
    endfunction

    function automatic logic [47:0] pop_expected();
        if (exp_q.size() == 0) return 48'hx;
        return exp_q.pop_front();
    endfunction

    // Called at a falling edge; the model mirrors the length clamp and the zero-length shortcut.
    task automatic do_start(input int n);
        start       = 1'b1;
        num_vectors = 5'(n);
        m_len       = (n > 16) ? 16 : n;
        m_cnt       = 0;
        for (int i = 0; i < 3; i++) m_acc[i] = '0;
        if (m_len == 0) exp_q.push_back(48'h0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        in_valid     = 1'b1;
        in_vector[0] = a;
        in_vector[1] = b;
        in_vector[2] = c;
        m_acc[0] = lane_add(m_acc[0], a);
        m_acc[1] = lane_add(m_acc[1], b);
        m_acc[2] = lane_add(m_acc[2], c);
        m_cnt++;
        if (m_cnt == m_len) exp_q.push_back({m_acc[0], m_acc[1], m_acc[2]});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checks_total++;
        if ({out_valid, in_ready, busy} !== 3'b000) $display("[TB] FAIL reset_ctrl: got %b expected 000", {out_valid, in_ready, busy});
        else checks_passed++;
        checks_total++;
        if (out_packed() !== 48'h0) $display("[TB] FAIL reset_vec: got %h expected 0", out_packed());
        else checks_passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [47:0] exp;
        out_ready = 1'b1;
        do_start(3);
        send_vec(1, 2, 3);
        send_vec(4, 5, 6);
        checks_total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL basic_early: out_valid got %b expected 0", out_valid);
        else checks_passed++;
        send_vec(7, 8, 9);
        checks_total++;
        if (out_valid !== 1'b1) $display("[TB] FAIL basic_latency: out_valid got %b expected 1", out_valid);
        else checks_passed++;
        exp = pop_expected();
        checks_total++;
        if (out_packed() !== exp) $display("[TB] FAIL basic_sum: got %h expected %h", out_packed(), exp);
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if ({out_valid, busy} !== 2'b00) $display("[TB] FAIL basic_idle: got %b expected 00", {out_valid, busy});
        else checks_passed++;
    endtask

    task automatic test_backpressure();
        logic [47:0] exp;
        out_ready = 1'b0;
        do_start(3);
        send_vec(1, 2, 3);
        send_vec(4, 5, 6);
        send_vec(7, 8, 9);
        exp = pop_expected();
        for (int c = 0; c < 5; c++) begin
            checks_total++;
            if ({out_valid, in_ready, busy} !== 3'b101) $display("[TB] FAIL bp_ctrl[%0d]: got %b expected 101", c, {out_valid, in_ready, busy});
            else checks_passed++;
            checks_total++;
            if (out_packed() !== exp) $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", c, out_packed(), exp);
            else checks_passed++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks_total++;
        if ({out_valid, busy} !== 2'b00) $display("[TB] FAIL bp_release: got %b expected 00", {out_valid, busy});
        else checks_passed++;
    endtask

    task automatic test_zero_length();
        logic [47:0] exp;
        out_ready = 1'b0;
        do_start(0);
        exp = pop_expected();
        for (int c = 0; c < 2; c++) begin
            checks_total++;
            if ({out_valid, in_ready} !== 2'b10) $display("[TB] FAIL zero_ctrl[%0d]: got %b expected 10", c, {out_valid, in_ready});
            else checks_passed++;
            checks_total++;
            if (out_packed() !== exp) $display("[TB] FAIL zero_vec[%0d]: got %h expected %h", c, out_packed(), exp);
            else checks_passed++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL zero_idle: busy got %b expected 0", busy);
        else checks_passed++;
    endtask

    task automatic test_overflow();
        logic [47:0] exp;
        out_ready = 1'b1;
        do_start(2);
        send_vec(16'hFFFF, 16'h0010, 16'h0000);
        send_vec(16'h0002, 16'h0020, 16'h0000);
        exp = pop_expected();
        checks_total++;
`ifdef VECTOR_ACC_SAT_EN
        if (out_vector[0] !== 16'hFFFF) $display("[TB] FAIL ovf_lane0: got %h expected ffff", out_vector[0]);
`else
        if (out_vector[0] !== 16'h0001) $display("[TB] FAIL ovf_lane0: got %h expected 0001", out_vector[0]);
`endif
        else checks_passed++;
        checks_total++;
        if ({out_valid, out_packed()} !== {1'b1, exp}) $display("[TB] FAIL ovf_vec: got %b/%h expected 1/%h", out_valid, out_packed(), exp);
        else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [47:0] exp;
        out_ready = 1'b1;
        do_start(2);
        send_vec(10, 20, 30);
        start       = 1'b1;
        num_vectors = 5'd5;
        @(negedge clk);
        start = 1'b0;
        send_vec(1, 1, 1);
        exp = pop_expected();
        checks_total++;
        if ({out_valid, out_packed()} !== {1'b1, exp}) $display("[TB] FAIL restart_len: got %b/%h expected 1/%h", out_valid, out_packed(), exp);
        else checks_passed++;
        start       = 1'b1;
        num_vectors = 5'd3;
        @(negedge clk);
        start = 1'b0;
        checks_total++;
        if ({busy, in_ready, out_valid} !== 3'b000) $display("[TB] FAIL start_on_handshake: got %b expected 000", {busy, in_ready, out_valid});
        else checks_passed++;
    endtask

    task automatic test_clamp();
        logic [47:0] exp;
        out_ready = 1'b1;
        do_start(20);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks_total++;
                if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL clamp_before_last: got %b expected 01", {out_valid, in_ready});
                else checks_passed++;
            end
            send_vec(16'(i), 16'(2 * i), 16'd100);
        end
        exp = pop_expected();
        checks_total++;
        if ({out_valid, in_ready} !== 2'b10) $display("[TB] FAIL clamp_end: got %b expected 10", {out_valid, in_ready});
        else checks_passed++;
        checks_total++;
        if (out_packed() !== exp) $display("[TB] FAIL clamp_sum: got %h expected %h", out_packed(), exp);
        else checks_passed++;
        out_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_midrun_reset();
        logic [47:0] exp;
        out_ready = 1'b1;
        do_start(3);
        send_vec(5, 5, 5);
        #2 reset = 1'b1;
        #1;
        checks_total++;
        if ({out_valid, in_ready, busy} !== 3'b000) $display("[TB] FAIL midreset_ctrl: got %b expected 000", {out_valid, in_ready, busy});
        else checks_passed++;
        checks_total++;
        if (out_packed() !== 48'h0) $display("[TB] FAIL midreset_vec: got %h expected 0", out_packed());
        else checks_passed++;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        do_start(3);
        send_vec(1, 2, 3);
        send_vec(1, 2, 3);
        send_vec(1, 2, 3);
        exp = pop_expected();
        checks_total++;
        if ({out_valid, out_packed()} !== {1'b1, exp}) $display("[TB] FAIL midreset_rerun: got %b/%h expected 1/%h", out_valid, out_packed(), exp);
        else checks_passed++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) in_vector[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_overflow();
        test_start_ignored();
        test_clamp();
        test_midrun_reset();
        checks_total++;
        if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
